// File: rtl/rns_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rns_pkg
//  Description : Shared helpers for the RNS comparator: conversion widths,
//                dynamic range M for the {2^N-1, 2^N, 2^N+1} moduli set,
//                and the one-hot compare-result encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package rns_pkg;

    // Width of the partial-conversion vectors (value modulo 2^(2N)-1)
    function automatic int rns_conv_w(input int n);
        return 2 * n;
    endfunction

    // Width of a fully reconstructed integer in [0, M)
    function automatic int rns_val_w(input int n);
        return 3 * n;
    endfunction

    // Dynamic range M = (2^N-1) * 2^N * (2^N+1); fits 64 bits for N <= 16
    function automatic logic [63:0] rns_m(input int n);
        logic [63:0] p;
        p = 64'd1 << n;
        return (p - 64'd1) * p * (p + 64'd1);
    endfunction

    // Signed threshold ceil(M/2); M is always even here
    function automatic logic [63:0] rns_half(input int n);
        return rns_m(n) >> 1;
    endfunction

    // Result encoding {lt, eq, gt}
    localparam logic [2:0] c_res_none = 3'b000;
    localparam logic [2:0] c_res_lt   = 3'b100;
    localparam logic [2:0] c_res_eq   = 3'b010;
    localparam logic [2:0] c_res_gt   = 3'b001;

endpackage
`default_nettype wire

// File: rtl/rns_partial_convert.sv
`default_nettype none
// ============================================================================
//  Module      : rns_partial_convert
//  Description : Combinational first step of residue-to-binary conversion.
//                Forms the upper part Y of X = x2 + 2^N * Y as a sum/carry
//                pair modulo 2^(2N)-1, using
//                Y = (2^(2N-1)+2^(N-1))*x1 - 2^N*x2
//                  + (2^(2N-1)+2^(N-1)-1)*x3   (mod 2^(2N)-1).
//                Multiplies by powers of two are rotations, negation is
//                bit inversion, and the carry-save tree wraps its carries.
//  Revision    : 1.0 - initial release
// ============================================================================
module rns_partial_convert
    import rns_pkg::*;
#(
    parameter int N = 3
)(
    input  logic [N-1:0]               i_x1,
    input  logic [N-1:0]               i_x2,
    input  logic [N:0]                 i_x3,
    output logic [rns_conv_w(N)-1:0]   o_sum,
    output logic [rns_conv_w(N)-1:0]   o_carry
);

    localparam int c_w = rns_conv_w(N);

    // Multiply by 2^k modulo 2^c_w - 1
    function automatic logic [c_w-1:0] rotl(input logic [c_w-1:0] v, input int k);
        return (v << k) | (v >> (c_w - k));
    endfunction

    // 3:2 compressor whose carry out of the MSB re-enters at the LSB
    function automatic logic [2*c_w-1:0] csa(input logic [c_w-1:0] x,
                                             input logic [c_w-1:0] y,
                                             input logic [c_w-1:0] z);
        logic [c_w-1:0] s;
        logic [c_w-1:0] m;
        s = x ^ y ^ z;
        m = (x & y) | (x & z) | (y & z);
        return {s, m[c_w-2:0], m[c_w-1]};
    endfunction

    logic [c_w-1:0] w_x1e, w_x2e, w_x3e;
    logic [c_w-1:0] w_t1, w_t2, w_t3, w_t4, w_t5, w_t6;
    logic [c_w-1:0] w_s1, w_c1, w_s2, w_c2, w_s3, w_c3;

    assign w_x1e = {{N{1'b0}}, i_x1};
    assign w_x2e = {{N{1'b0}}, i_x2};
    assign w_x3e = {{(N-1){1'b0}}, i_x3};

    // Weighted terms of the conversion
    assign w_t1 = rotl(w_x1e, c_w - 1);
    assign w_t2 = rotl(w_x1e, N - 1);
    assign w_t3 = rotl(w_x3e, c_w - 1);
    assign w_t4 = rotl(w_x3e, N - 1);
    assign w_t5 = ~w_x3e;
    assign w_t6 = ~rotl(w_x2e, N);

    // Six terms reduced to two
    assign {w_s1, w_c1}      = csa(w_t1, w_t2, w_t3);
    assign {w_s2, w_c2}      = csa(w_t4, w_t5, w_t6);
    assign {w_s3, w_c3}      = csa(w_s1, w_c1, w_s2);
    assign {o_sum, o_carry}  = csa(w_s3, w_c3, w_c2);

endmodule
`default_nettype wire

// File: rtl/rns_compare_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : rns_compare_pipe
//  Description : Three-stage pipelined magnitude comparator for operands in
//                residue form over {2^N-1, 2^N, 2^N+1}, unsigned or signed,
//                with valid/ready flow control and illegal-residue detect.
//                S1: capture + partial conversion, S2: final conversion and
//                subtract/sign recognition, S3: registered decision.
//  Revision    : 1.0 - initial release
// ============================================================================
module rns_compare_pipe
    import rns_pkg::*;
#(
    parameter int N         = 3,
    parameter int SIGNED_EN = 1
)(
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         valid_in,
    output logic         ready_out,
    input  logic [N-1:0] a1_in,
    input  logic [N-1:0] b1_in,
    input  logic [N-1:0] a2_in,
    input  logic [N-1:0] b2_in,
    input  logic [N:0]   a3_in,
    input  logic [N:0]   b3_in,
    input  logic         mode_in,
    output logic         valid_out,
    input  logic         ready_in,
    output logic         res_le_out,
    output logic         res_eq_out,
    output logic         res_gr_out,
    output logic         err_out
);

    localparam int          c_w      = rns_conv_w(N);
    localparam int          c_vw     = rns_val_w(N);
    localparam logic [63:0] c_half   = rns_half(N);
    localparam logic [N:0]  c_m3_max = {1'b1, {N{1'b0}}};

    // End-around-carry add modulo 2^c_w - 1, all-ones folded to zero
    function automatic logic [c_w-1:0] eac_sum(input logic [c_w-1:0] s,
                                               input logic [c_w-1:0] c);
        logic [c_w:0]   t;
        logic [c_w-1:0] y;
        t = {1'b0, s} + {1'b0, c};
        y = t[c_w-1:0] + {{(c_w-1){1'b0}}, t[c_w]};
        return (&y) ? '0 : y;
    endfunction

    // ------------------------------------------------------------------
    // Flow control: every stage moves on the same enable
    // ------------------------------------------------------------------
    logic w_adv;
    logic r_v1, r_v2, r_v3;

    assign w_adv     = ~r_v3 | ready_in;
    assign ready_out = w_adv;

    // ------------------------------------------------------------------
    // Input side: normalisation, legality, equality short path, mode
    // ------------------------------------------------------------------
    logic [N-1:0]   w_a1n, w_b1n;
    logic           w_err_in, w_eq_in, w_mode;
    logic [c_w-1:0] w_sa, w_ca, w_sb, w_cb;

    assign w_a1n    = (&a1_in) ? '0 : a1_in;
    assign w_b1n    = (&b1_in) ? '0 : b1_in;
    assign w_err_in = (a3_in > c_m3_max) | (b3_in > c_m3_max);
    assign w_eq_in  = (w_a1n == w_b1n) && (a2_in == b2_in) && (a3_in == b3_in);

    generate
        if (SIGNED_EN != 0) begin : g_signed_mode
            assign w_mode = mode_in;
        end else begin : g_unsigned_mode
            assign w_mode = 1'b0;
        end
    endgenerate

    rns_partial_convert #(.N(N)) u_conv_a (
        .i_x1    (w_a1n),
        .i_x2    (a2_in),
        .i_x3    (a3_in),
        .o_sum   (w_sa),
        .o_carry (w_ca)
    );

    rns_partial_convert #(.N(N)) u_conv_b (
        .i_x1    (w_b1n),
        .i_x2    (b2_in),
        .i_x3    (b3_in),
        .o_sum   (w_sb),
        .o_carry (w_cb)
    );

    // ------------------------------------------------------------------
    // S1 registers
    // ------------------------------------------------------------------
    logic [c_w-1:0] r_sa1, r_ca1, r_sb1, r_cb1;
    logic [N-1:0]   r_a2_1, r_b2_1;
    logic           r_eq1, r_err1, r_mode1;

    // S1 valid bit
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_v1 <= 1'b0;
        end else if (w_adv) begin
            r_v1 <= valid_in;
        end
    end

    // S1 data: partial conversion vectors and side information
    always_ff @(posedge clk_in) begin
        if (w_adv) begin
            r_sa1   <= w_sa;
            r_ca1   <= w_ca;
            r_sb1   <= w_sb;
            r_cb1   <= w_cb;
            r_a2_1  <= a2_in;
            r_b2_1  <= b2_in;
            r_eq1   <= w_eq_in;
            r_err1  <= w_err_in;
            r_mode1 <= w_mode;
        end
    end

    // ------------------------------------------------------------------
    // S2 logic: resolve Y, rebuild X = {Y, x2}, subtract and sign detect
    // ------------------------------------------------------------------
    logic [c_w-1:0]  w_ya, w_yb;
    logic [c_vw-1:0] w_xa, w_xb;
    logic            w_ge, w_nega, w_negb;

    assign w_ya   = eac_sum(r_sa1, r_ca1);
    assign w_yb   = eac_sum(r_sb1, r_cb1);
    assign w_xa   = {w_ya, r_a2_1};
    assign w_xb   = {w_yb, r_b2_1};
    // Carry out of A - B: set when A >= B
    assign w_ge   = (w_xa >= w_xb);
    assign w_nega = ({{(64-c_vw){1'b0}}, w_xa} >= c_half);
    assign w_negb = ({{(64-c_vw){1'b0}}, w_xb} >= c_half);

    logic r_eq2, r_err2, r_mode2, r_ge2, r_nega2, r_negb2;

    // S2 valid bit
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_v2 <= 1'b0;
        end else if (w_adv) begin
            r_v2 <= r_v1;
        end
    end

    // S2 data: compare flags
    always_ff @(posedge clk_in) begin
        if (w_adv) begin
            r_eq2   <= r_eq1;
            r_err2  <= r_err1;
            r_mode2 <= r_mode1;
            r_ge2   <= w_ge;
            r_nega2 <= w_nega;
            r_negb2 <= w_negb;
        end
    end

    // ------------------------------------------------------------------
    // S3: final decision, forced to zero for bubbles and illegal input
    // ------------------------------------------------------------------
    logic [2:0] w_res;
    logic [2:0] r_res;
    logic       r_err3;

    // Decide lt/eq/gt; signs that differ settle a signed compare directly
    always_comb begin
        w_res = c_res_none;
        if (r_v2 && !r_err2) begin
            if (r_eq2) begin
                w_res = c_res_eq;
            end else if (r_mode2 && (r_nega2 != r_negb2)) begin
                w_res = r_nega2 ? c_res_lt : c_res_gt;
            end else begin
                w_res = r_ge2 ? c_res_gt : c_res_lt;
            end
        end
    end

    // S3 output registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_v3   <= 1'b0;
            r_res  <= c_res_none;
            r_err3 <= 1'b0;
        end else if (w_adv) begin
            r_v3   <= r_v2;
            r_res  <= w_res;
            r_err3 <= r_v2 & r_err2;
        end
    end

    assign valid_out  = r_v3;
    assign res_le_out = r_res[2];
    assign res_eq_out = r_res[1];
    assign res_gr_out = r_res[0];
    assign err_out    = r_err3;

endmodule
`default_nettype wire

// File: tb/tb_rns_compare_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rns_compare_pipe
//  Description : Directed bench for rns_compare_pipe at N=3 (M=504).
//                Result nibble is {le, eq, gr, err}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rns_compare_pipe;

    localparam int N = 3;

    localparam logic [3:0] LT  = 4'b1000;
    localparam logic [3:0] EQ  = 4'b0100;
    localparam logic [3:0] GT  = 4'b0010;
    localparam logic [3:0] ERR = 4'b0001;

    logic         clk = 1'b0;
    logic         rst_in = 1'b1;
    logic         valid_in = 1'b0;
    logic         ready_out;
    logic [N-1:0] a1 = '0, b1 = '0, a2 = '0, b2 = '0;
    logic [N:0]   a3 = '0, b3 = '0;
    logic         mode = 1'b0;
    logic         valid_out;
    logic         ready_in = 1'b1;
    logic         le, eq, gr, err;

    int n_vec = 0;
    int n_bad = 0;

    rns_compare_pipe #(.N(N), .SIGNED_EN(1)) dut (
        .clk_in     (clk),
        .rst_in     (rst_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .a1_in      (a1),
        .b1_in      (b1),
        .a2_in      (a2),
        .b2_in      (b2),
        .a3_in      (a3),
        .b3_in      (b3),
        .mode_in    (mode),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .res_le_out (le),
        .res_eq_out (eq),
        .res_gr_out (gr),
        .err_out    (err)
    );

    always #5 clk = ~clk;

    // Packed vector layout: {a1,a2,a3,b1,b2,b3,mode} = 3+3+4+3+3+4+1 bits
    task automatic drive(input logic [20:0] v);
        a1   = v[20:18];
        a2   = v[17:15];
        a3   = v[14:11];
        b1   = v[10:8];
        b2   = v[7:5];
        b3   = v[4:1];
        mode = v[0];
    endtask

    // One operand pair through an empty pipe; lat counts cycles to valid_out
    task automatic send_one(input logic [20:0] v, output logic [3:0] r, output int lat);
        @(negedge clk);
        drive(v);
        valid_in = 1'b1;
        ready_in = 1'b1;
        lat = -1;
        r   = 4'bxxxx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            valid_in = 1'b0;
            if (valid_out) begin
                lat = k;
                r   = {le, eq, gr, err};
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_in   = 1'b1;
        valid_in = 1'b1;
        ready_in = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({valid_out, le, eq, gr, err} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b required 00000", {valid_out, le, eq, gr, err});
        end
        valid_in = 1'b0;
        rst_in   = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (ready_out !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b required 1", ready_out);
        end
        n_vec++;
        if (valid_out !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid_after_release: got %b required 0", valid_out);
        end
    endtask

    task automatic test_unsigned();
        logic [3:0] r;
        int         lat;
        // 100 vs 200
        send_one({3'd2, 3'd4, 4'd1, 3'd4, 3'd0, 4'd2, 1'b0}, r, lat);
        n_vec++;
        if (r !== LT) begin
            n_bad++;
            $display("FAIL unsigned_100_200: got %b required %b", r, LT);
        end
        n_vec++;
        if (lat !== 3) begin
            n_bad++;
            $display("FAIL latency: got %0d required 3", lat);
        end
        // 8 (mod-9 residue at its legal maximum) vs 9
        send_one({3'd1, 3'd0, 4'd8, 3'd2, 3'd1, 4'd0, 1'b0}, r, lat);
        n_vec++;
        if (r !== LT) begin
            n_bad++;
            $display("FAIL unsigned_8_9: got %b required %b", r, LT);
        end
        // 503 vs 0
        send_one({3'd6, 3'd7, 4'd8, 3'd0, 3'd0, 4'd0, 1'b0}, r, lat);
        n_vec++;
        if (r !== GT) begin
            n_bad++;
            $display("FAIL unsigned_503_0: got %b required %b", r, GT);
        end
    endtask

    task automatic test_signed();
        logic [20:0] v [0:5];
        logic [3:0]  e [0:5];
        logic [3:0]  r;
        int          lat;
        v[0] = {3'd6, 3'd4, 4'd3, 3'd2, 3'd4, 4'd1, 1'b0}; e[0] = GT; // 300 vs 100
        v[1] = {3'd6, 3'd4, 4'd3, 3'd2, 3'd4, 4'd1, 1'b1}; e[1] = LT; // -204 vs 100
        v[2] = {3'd6, 3'd3, 4'd8, 3'd0, 3'd4, 4'd0, 1'b0}; e[2] = LT; // 251 vs 252
        v[3] = {3'd6, 3'd3, 4'd8, 3'd0, 3'd4, 4'd0, 1'b1}; e[3] = GT; // 251 vs -252
        v[4] = {3'd6, 3'd7, 4'd8, 3'd0, 3'd0, 4'd0, 1'b1}; e[4] = LT; // -1 vs 0
        v[5] = {3'd0, 3'd4, 4'd0, 3'd6, 3'd7, 4'd8, 1'b1}; e[5] = LT; // -252 vs -1
        for (int i = 0; i < 6; i++) begin
            send_one(v[i], r, lat);
            n_vec++;
            if (r !== e[i]) begin
                n_bad++;
                $display("FAIL signed_%0d: got %b required %b", i, r, e[i]);
            end
        end
    endtask

    task automatic test_equal();
        logic [20:0] v [0:3];
        logic [3:0]  r;
        int          lat;
        v[0] = {3'd0, 3'd0, 4'd0, 3'd7, 3'd0, 4'd0, 1'b0}; // 0 vs alias of 0
        v[1] = {3'd2, 3'd4, 4'd1, 3'd2, 3'd4, 4'd1, 1'b0}; // 100 vs 100
        v[2] = {3'd7, 3'd4, 4'd1, 3'd0, 3'd4, 4'd1, 1'b1}; // alias, signed mode
        v[3] = {3'd1, 3'd0, 4'd8, 3'd1, 3'd0, 4'd8, 1'b1}; // 8 vs 8
        for (int i = 0; i < 4; i++) begin
            send_one(v[i], r, lat);
            n_vec++;
            if (r !== EQ) begin
                n_bad++;
                $display("FAIL equal_%0d: got %b required %b", i, r, EQ);
            end
        end
    endtask

    task automatic test_illegal();
        logic [3:0] r;
        int         lat;
        send_one({3'd2, 3'd4, 4'd10, 3'd4, 3'd0, 4'd2, 1'b0}, r, lat);
        n_vec++;
        if (r !== ERR) begin
            n_bad++;
            $display("FAIL illegal_a3: got %b required %b", r, ERR);
        end
        send_one({3'd2, 3'd4, 4'd1, 3'd2, 3'd4, 4'd9, 1'b1}, r, lat);
        n_vec++;
        if (r !== ERR) begin
            n_bad++;
            $display("FAIL illegal_b3: got %b required %b", r, ERR);
        end
    endtask

    task automatic test_back_to_back();
        logic [20:0] v [0:5];
        logic [3:0]  e [0:5];
        int          idx;
        int          got;
        v[0] = {3'd2, 3'd4, 4'd1,  3'd4, 3'd0, 4'd2, 1'b0}; e[0] = LT;
        v[1] = {3'd6, 3'd4, 4'd3,  3'd2, 3'd4, 4'd1, 1'b0}; e[1] = GT;
        v[2] = {3'd0, 3'd0, 4'd0,  3'd7, 3'd0, 4'd0, 1'b0}; e[2] = EQ;
        v[3] = {3'd2, 3'd4, 4'd10, 3'd4, 3'd0, 4'd2, 1'b0}; e[3] = ERR;
        v[4] = {3'd6, 3'd4, 4'd3,  3'd2, 3'd4, 4'd1, 1'b1}; e[4] = LT;
        v[5] = {3'd4, 3'd0, 4'd2,  3'd0, 3'd0, 4'd0, 1'b0}; e[5] = GT;
        idx = 0;
        got = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            ready_in = !(cyc == 4 || cyc == 5);
            if (idx < 6) begin
                drive(v[idx]);
                valid_in = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            #1;
            if (cyc == 4 || cyc == 5) begin
                n_vec++;
                if (ready_out !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stall_ready_cyc%0d: got %b required 0", cyc, ready_out);
                end
            end
            if (valid_out && ready_in) begin
                n_vec++;
                if (got >= 6) begin
                    n_bad++;
                    $display("FAIL b2b_extra_result: got %b required none", {le, eq, gr, err});
                end else if ({le, eq, gr, err} !== e[got]) begin
                    n_bad++;
                    $display("FAIL b2b_result_%0d: got %b required %b", got, {le, eq, gr, err}, e[got]);
                end
                got++;
            end
            if (valid_in && ready_out) idx++;
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        n_vec++;
        if (got !== 6) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d required 6", got);
        end
    endtask

    task automatic test_reset_midstream();
        logic [20:0] v [0:2];
        logic [3:0]  r;
        int          lat;
        int          stale;
        v[0] = {3'd2, 3'd4, 4'd1, 3'd4, 3'd0, 4'd2, 1'b0};
        v[1] = {3'd6, 3'd4, 4'd3, 3'd2, 3'd4, 4'd1, 1'b0};
        v[2] = {3'd0, 3'd0, 4'd0, 3'd7, 3'd0, 4'd0, 1'b0};
        @(negedge clk);
        ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(v[i]);
            valid_in = 1'b1;
            @(negedge clk);
        end
        valid_in = 1'b0;
        n_vec++;
        if (valid_out !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_pipe_full: got %b required 1", valid_out);
        end
        rst_in = 1'b1;
        #1;
        n_vec++;
        if ({valid_out, le, eq, gr, err} !== 5'b0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %b required 00000", {valid_out, le, eq, gr, err});
        end
        repeat (2) @(negedge clk);
        rst_in = 1'b0;
        stale = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (valid_out) stale++;
        end
        n_vec++;
        if (stale !== 0) begin
            n_bad++;
            $display("FAIL midreset_stale: got %0d results required 0", stale);
        end
        send_one(v[1], r, lat);
        n_vec++;
        if (r !== GT) begin
            n_bad++;
            $display("FAIL midreset_recover: got %b required %b", r, GT);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_equal();
        test_illegal();
        test_back_to_back();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
